// File: rtl/keypad_pkg.sv
// Shared types and helpers for the key-matrix scanner.
package keypad_pkg;

  // Wide enough for any practical matrix; the top truncates to its own KW.
  localparam int unsigned KEY_CODE_W = 16;

  typedef enum logic [1:0] {
    DRIVE,
    SAMPLE,
    EMIT,
    ADVANCE
  } scan_state_t;

  typedef struct packed {
    logic [KEY_CODE_W-1:0] code;
    logic                  pressed;
  } key_event_t;

  // Key index within the matrix: row-major, columns fastest.
  function automatic int unsigned idx(input int unsigned row,
                                      input int unsigned col,
                                      input int unsigned n_col);
    return row * n_col + col;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key's debounce state: a disagreement counter plus the stable level.
module key_debounce_cell #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic sample_en,
  input  logic sample_bit,
  input  logic commit,
  output logic change,
  output logic stable
);

  localparam int unsigned CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

  logic [CW-1:0] cnt_q;
  logic          disagree;
  logic          at_limit;

  assign disagree = sample_bit ^ stable;
  assign at_limit = (cnt_q == CW'(DEBOUNCE_SCANS - 1));
  assign change   = sample_en & disagree & at_limit;

  // Counter restarts on any agreeing sample or when the threshold is reached;
  // the stable level only flips when the emitter commits the change.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q  <= '0;
      stable <= 1'b0;
    end else begin
      if (sample_en) begin
        cnt_q <= (disagree && !at_limit) ? cnt_q + 1'b1 : '0;
      end
      if (commit) begin
        stable <= ~stable;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Column-scanned key matrix with per-key debounce, toggle vector and event stream.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter  int unsigned N_COL          = 3,
  parameter  int unsigned N_ROW          = 4,
  parameter  int unsigned SCAN_DIV       = 1000,
  parameter  int unsigned DEBOUNCE_SCANS = 4,
  parameter  bit          ACTIVE_LOW     = 1'b1,
  localparam int unsigned N_KEY          = N_COL * N_ROW,
  localparam int unsigned KW             = $clog2(N_KEY)
) (
  input  logic             aclk,
  input  logic             aresetn,
  output logic [N_COL-1:0] O_BUTTON_COL,
  input  logic [N_ROW-1:0] I_BUTTON_ROW,
  input  logic             i_save_clear,
  output logic [N_KEY-1:0] o_key_push,
  output logic [N_KEY-1:0] o_key_save,
  output logic             o_key_valid,
  output logic [KW-1:0]    o_key_code,
  output logic             o_key_pressed
);

  localparam int unsigned CIW = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int unsigned RW  = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int unsigned SW  = $clog2(SCAN_DIV);
  // SAMPLE, N_ROW EMIT cycles and ADVANCE fill the tail of each slot, so the
  // whole slot stays exactly SCAN_DIV cycles; DRIVE gets the remainder (>= 2,
  // which covers the 2-FF synchroniser latency).
  localparam int unsigned SAMPLE_AT = SCAN_DIV - N_ROW - 2;
  localparam logic [N_ROW-1:0] ROW_IDLE = ACTIVE_LOW ? '1 : '0;

  scan_state_t    state_q, state_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic [RW-1:0]  row_ptr_q, row_ptr_d;
  logic [CIW-1:0] col_idx_q, col_idx_d;
  logic           started_q;

  logic [N_ROW-1:0] sync1_q, sync2_q, row_pressed;
  logic [N_ROW-1:0] change_mask_q, level_mask_q, col_change;
  logic [N_KEY-1:0] change_vec, commit_vec, key_stable, save_q;
  logic [N_COL-1:0] col_onehot;
  logic             sample_phase, emit_fire, emit_level, ev_valid_q;
  key_event_t       ev_q, ev_d;

  assign sample_phase = (state_q == SAMPLE);
  assign row_pressed  = ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign emit_level   = level_mask_q[row_ptr_q];

  assign o_key_push    = key_stable;
  assign o_key_save    = save_q;
  assign o_key_valid   = ev_valid_q;
  assign o_key_code    = KW'(ev_q.code);
  assign o_key_pressed = ev_q.pressed;

  // Column drive; held inactive until the first cycle after reset so every
  // slot, including the first, shows its column for the full SCAN_DIV cycles.
  always_comb begin
    col_onehot = '0;
    if (started_q) col_onehot[col_idx_q] = 1'b1;
    O_BUTTON_COL = ACTIVE_LOW ? ~col_onehot : col_onehot;
  end

  // Two-stage synchroniser on the raw row pins.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1_q <= ROW_IDLE;
      sync2_q <= ROW_IDLE;
    end else begin
      sync1_q <= I_BUTTON_ROW;
      sync2_q <= sync1_q;
    end
  end

  // Debounce cells, one per key; keys of a row are contiguous in the index space.
  for (genvar r = 0; r < N_ROW; r++) begin : g_row
    for (genvar c = 0; c < N_COL; c++) begin : g_col
      localparam int unsigned K = idx(r, c, N_COL);
      assign commit_vec[K] = emit_fire && (row_ptr_q == RW'(r)) && (col_idx_q == CIW'(c));
      key_debounce_cell #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_cell (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .sample_en (sample_phase && (col_idx_q == CIW'(c))),
        .sample_bit(row_pressed[r]),
        .commit    (commit_vec[K]),
        .change    (change_vec[K]),
        .stable    (key_stable[K])
      );
    end
    assign col_change[r] = |change_vec[idx(r, 0, N_COL) +: N_COL];
  end

  // Scan FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= DRIVE;
      slot_q    <= '0;
      row_ptr_q <= '0;
      col_idx_q <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      row_ptr_q <= row_ptr_d;
      col_idx_q <= col_idx_d;
      started_q <= 1'b1;
    end
  end

  // Scan FSM next state and event selection.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    row_ptr_d = row_ptr_q;
    col_idx_d = col_idx_q;
    emit_fire = 1'b0;
    ev_d.code    = KEY_CODE_W'(idx(32'(row_ptr_q), 32'(col_idx_q), N_COL));
    ev_d.pressed = emit_level;
    case (state_q)
      DRIVE: begin
        if (started_q) begin
          slot_d = slot_q + 1'b1;
          if (slot_q == SW'(SAMPLE_AT - 1)) state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        row_ptr_d = '0;
        state_d   = EMIT;
      end
      EMIT: begin
        emit_fire = change_mask_q[row_ptr_q];
        if (row_ptr_q == RW'(N_ROW - 1)) state_d = ADVANCE;
        else row_ptr_d = row_ptr_q + 1'b1;
      end
      ADVANCE: begin
        slot_d    = '0;
        col_idx_d = (col_idx_q == CIW'(N_COL - 1)) ? '0 : col_idx_q + 1'b1;
        state_d   = DRIVE;
      end
      default: state_d = DRIVE;
    endcase
  end

  // Change capture, event output and save-toggle registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      change_mask_q <= '0;
      level_mask_q  <= '0;
      ev_valid_q    <= 1'b0;
      ev_q          <= '0;
      save_q        <= '0;
    end else begin
      if (sample_phase) begin
        change_mask_q <= col_change;
        level_mask_q  <= row_pressed;
      end
      ev_valid_q <= emit_fire;
      if (emit_fire) ev_q <= ev_d;
      save_q <= i_save_clear ? '0 : save_q ^ (commit_vec & {N_KEY{emit_level}});
    end
  end

endmodule
